// File: rtl/fpu_pkg.sv
// Shared floating-point format helpers for the adder datapath.
// Selects single or double precision field widths from one bit.
package fpu_pkg;

    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;
    localparam int DP_EXP_W = 11;
    localparam int DP_MAN_W = 52;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic zero;
    } fpu_flags_t;

    function automatic int fpu_exp_w(input bit dbl);
        return dbl ? DP_EXP_W : SP_EXP_W;
    endfunction

    function automatic int fpu_man_w(input bit dbl);
        return dbl ? DP_MAN_W : SP_MAN_W;
    endfunction

    function automatic int fpu_size(input bit dbl);
        return 1 + fpu_exp_w(dbl) + fpu_man_w(dbl);
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; returns WIDTH when the input is all zeros.
module fpu_lzc #(
    parameter int WIDTH = 24,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Ascending scan so the most significant set bit is the last to write.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_add_normalize.sv
// Two-stage post-add normalizer producing a packed IEEE-754 word (truncating).
// Optional status flags are built when FPU_NORM_FLAGS_EN is defined.
module fpu_add_normalize
    import fpu_pkg::*;
#(
    parameter bit double = 1'b0,
    localparam int EXP_W = fpu_exp_w(double),
    localparam int MAN_W = fpu_man_w(double),
    localparam int SIZE  = fpu_size(double)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+1:0] in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_result
`ifdef FPU_NORM_FLAGS_EN
    ,
    output logic [2:0]       out_flags
`endif
);

    localparam int LZ_W = $clog2(MAN_W + 2);
    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

    logic             s2_adv;
    logic             s1_adv;
    logic [LZ_W-1:0]  lz_next;

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [MAN_W:0]   s1_mant_reg;
    logic             s1_carry_reg;
    logic             s1_zero_reg;
    logic             s1_inf_reg;
    logic [LZ_W-1:0]  s1_lz_reg;

    logic             out_valid_reg;
    logic [SIZE-1:0]  out_result_reg;
    logic [SIZE-1:0]  result_next;

    logic [EXP_W:0]   exp_ext;
    logic [EXP_W:0]   lz_ext;
    logic [EXP_W:0]   exp_inc;
    logic [EXP_W-1:0] exp_sub;
    logic [MAN_W-1:0] frac_shift;

    assign s2_adv   = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    fpu_lzc #(
        .WIDTH (MAN_W + 1)
    ) u_lzc (
        .value (in_mant[MAN_W:0]),
        .count (lz_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_mant_reg  <= '0;
            s1_carry_reg <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_inf_reg   <= 1'b0;
            s1_lz_reg    <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg  <= in_sign;
                s1_exp_reg   <= in_exp;
                s1_mant_reg  <= in_mant[MAN_W:0];
                s1_carry_reg <= in_mant[MAN_W+1];
                s1_zero_reg  <= (in_mant == '0);
                s1_inf_reg   <= (in_exp == EXP_ALL1);
                s1_lz_reg    <= lz_next;
            end
        end
    end

    // Exponent math is one bit wider than the field so nothing wraps.
    assign exp_ext    = {1'b0, s1_exp_reg};
    assign lz_ext     = (EXP_W + 1)'(s1_lz_reg);
    assign exp_inc    = exp_ext + 1'b1;
    assign exp_sub    = EXP_W'(exp_ext - lz_ext);
    assign frac_shift = MAN_W'(s1_mant_reg << s1_lz_reg);

`ifdef FPU_NORM_FLAGS_EN
    fpu_flags_t flags_next;
    fpu_flags_t flags_reg;
`endif

    always_comb begin
        result_next = '0;
`ifdef FPU_NORM_FLAGS_EN
        flags_next  = '0;
`endif
        if (s1_inf_reg) begin
            result_next = {s1_sign_reg, EXP_ALL1, {MAN_W{1'b0}}};
`ifdef FPU_NORM_FLAGS_EN
            flags_next.overflow = 1'b1;
`endif
        end else if (s1_zero_reg) begin
            result_next = '0;
`ifdef FPU_NORM_FLAGS_EN
            flags_next.zero = 1'b1;
`endif
        end else if (s1_carry_reg) begin
            if (exp_inc == {1'b0, EXP_ALL1}) begin
                result_next = {s1_sign_reg, EXP_ALL1, {MAN_W{1'b0}}};
`ifdef FPU_NORM_FLAGS_EN
                flags_next.overflow = 1'b1;
`endif
            end else begin
                result_next = {s1_sign_reg, exp_inc[EXP_W-1:0], s1_mant_reg[MAN_W:1]};
            end
        end else if (lz_ext < exp_ext) begin
            result_next = {s1_sign_reg, exp_sub, frac_shift};
        end else begin
            // No denormal support: anything that would need one flushes to signed zero.
            result_next = {s1_sign_reg, {(SIZE-1){1'b0}}};
`ifdef FPU_NORM_FLAGS_EN
            flags_next.underflow = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_result_reg <= result_next;
            end
        end
    end

`ifdef FPU_NORM_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_reg <= '0;
        end else if (s2_adv && s1_valid_reg) begin
            flags_reg <= flags_next;
        end
    end

    assign out_flags = flags_reg;
`endif

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;

endmodule

// File: tb/tb_fpu_add_normalize.sv
// Directed self-checking bench for fpu_add_normalize (single and double instances).
module tb_fpu_add_normalize;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;

    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic        d_in_sign = 1'b0;
    logic [10:0] d_in_exp = '0;
    logic [53:0] d_in_mant = '0;
    logic        d_out_valid;
    logic        d_out_ready = 1'b1;
    logic [63:0] d_out_result;

`ifdef FPU_NORM_FLAGS_EN
    logic [2:0]  out_flags;
    logic [2:0]  d_out_flags;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fpu_add_normalize #(.double(1'b0)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FPU_NORM_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    fpu_add_normalize #(.double(1'b1)) dut_d (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d_in_valid),
        .in_ready   (d_in_ready),
        .in_sign    (d_in_sign),
        .in_exp     (d_in_exp),
        .in_mant    (d_in_mant),
        .out_valid  (d_out_valid),
        .out_ready  (d_out_ready),
        .out_result (d_out_result)
`ifdef FPU_NORM_FLAGS_EN
        ,
        .out_flags  (d_out_flags)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_single(input string tag, input logic sign, input logic [7:0] e,
                              input logic [24:0] m, input logic [31:0] res, input logic [2:0] flg);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = sign;
        in_exp   = e;
        in_mant  = m;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, 64'(out_result), 64'(res));
`ifdef FPU_NORM_FLAGS_EN
        check({tag, "_flags"}, 64'(out_flags), 64'(flg));
`endif
        $display("[TB] %s: result %h", tag, out_result);
    endtask

    logic        v_sign [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  v_exp  [4] = '{8'd127, 8'd127, 8'd128, 8'd200};
    logic [24:0] v_mant [4] = '{25'h1000000, 25'h0400000, 25'h0C00000, 25'h0000001};
    logic [31:0] v_res  [4] = '{32'h40000000, 32'h3F000000, 32'hC0400000, 32'h58800000};

    initial begin
        logic [31:0] q[$];
        logic [31:0] expect_word;
        int acc;
        int got;

        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", 64'(out_result), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef FPU_NORM_FLAGS_EN
        check("reset_flags", 64'(out_flags), 64'd0);
`endif
        rst = 1'b0;

        run_single("add_1p1",      1'b0, 8'd127, 25'h1000000, 32'h40000000, 3'b000);
        run_single("cancel_lz1",   1'b0, 8'd127, 25'h0400000, 32'h3F000000, 3'b000);
        run_single("zero_in",      1'b1, 8'd130, 25'h0000000, 32'h00000000, 3'b001);
        run_single("carry_ovf",    1'b1, 8'd254, 25'h1000000, 32'hFF800000, 3'b100);
        run_single("underflow",    1'b0, 8'd3,   25'h0000001, 32'h00000000, 3'b010);
        run_single("carry_trunc",  1'b0, 8'd127, 25'h1800001, 32'h40400000, 3'b000);
        run_single("inf_in",       1'b0, 8'd255, 25'h0800000, 32'h7F800000, 3'b100);
        run_single("min_normal",   1'b0, 8'd1,   25'h0800000, 32'h00800000, 3'b000);
        run_single("uflow_signed", 1'b1, 8'd1,   25'h0400000, 32'h80000000, 3'b010);
        run_single("shift_22",     1'b1, 8'd130, 25'h0000003, 32'hB6400000, 3'b000);
        run_single("lz_eq_exp",    1'b0, 8'd22,  25'h0000003, 32'h00000000, 3'b010);
        run_single("lz_exp_m1",    1'b0, 8'd23,  25'h0000003, 32'h00C00000, 3'b000);

        // Stalled stream: downstream blocked for 6 cycles, then drains in order.
        acc = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_valid  = (acc < 4);
            if (acc < 4) begin
                in_sign = v_sign[acc];
                in_exp  = v_exp[acc];
                in_mant = v_mant[acc];
            end
            #1;
            if (cyc == 2) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_accepted", 64'(acc), 64'd2);
            end
            if (cyc == 5) begin
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_result", 64'(out_result), 64'h40000000);
            end
            if (out_valid && out_ready) begin
                expect_word = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
                check("stream_order", 64'(out_result), 64'(expect_word));
                $display("[TB] stream out %0d: %h", got, out_result);
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(v_res[acc]);
                acc++;
            end
        end
        in_valid = 1'b0;
        check("stream_count", 64'(got), 64'd4);

        // Reset with both stages full: output must vanish immediately.
        @(negedge clk);
        in_valid = 1'b1; in_sign = v_sign[0]; in_exp = v_exp[0]; in_mant = v_mant[0];
        @(negedge clk);
        in_sign = v_sign[1]; in_exp = v_exp[1]; in_mant = v_mant[1];
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end

        // Double precision: 1.0 + 1.0.
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in_sign  = 1'b0;
        d_in_exp   = 11'd1023;
        d_in_mant  = 54'h20000000000000;
        #1;
        check("dbl_in_ready", 64'(d_in_ready), 64'd1);
        @(negedge clk);
        d_in_valid = 1'b0;
        check("dbl_latency", 64'(d_out_valid), 64'd0);
        @(negedge clk);
        check("dbl_valid", 64'(d_out_valid), 64'd1);
        check("dbl_result", d_out_result, 64'h4000000000000000);
`ifdef FPU_NORM_FLAGS_EN
        check("dbl_flags", 64'(d_out_flags), 64'd0);
`endif
        $display("[TB] dbl_add_1p1: result %h", d_out_result);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
